// File: rtl/redun_mont_pkg.sv
// redun_mont_pkg: shared redundant-number types plus the squaring driver's state and error encodings
package redun_mont_pkg;
    localparam int NUM_WRDS = 4;
    localparam int WRD_BITS = 16;
    typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] redun0_t;
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_LOCK, S_ISSUE, S_WAIT_RES, S_DONE, S_ERR
    } drv_state_t;
    typedef enum logic [1:0] {
        ERR_NONE, ERR_TIMEOUT, ERR_LOCK, ERR_SPUR
    } drv_err_t;
endpackage

// File: rtl/redun_sq_driver_if.sv
// redun_sq_driver_if: request/result link between the squaring driver and the clock-crossed wrapper
//   start  : request strobe (wrapper i_start)
//   sq_in  : operand to the wrapper
//   sq_out : result from the wrapper
//   valid  : result valid
//   locked : wrapper clock locked, already synchronised
interface redun_sq_driver_if;
    import redun_mont_pkg::*;
    logic    start;
    redun0_t sq_in;
    redun0_t sq_out;
    logic    valid;
    logic    locked;
    modport master (output start, sq_in, input sq_out, valid, locked);
    modport slave  (input start, sq_in, output sq_out, valid, locked);
endinterface

// File: rtl/redun_sq_driver.sv
// redun_sq_driver: iterates T Montgomery squarings through the wrapper, one request in flight at a time
//   i_clk/i_reset : clock, asynchronous active-high reset
//   i_start, i_sq, i_iter : command pulse, initial value, iteration count (accepted in IDLE/ERR)
//   o_busy, o_done, o_sq, o_iter_cnt, o_err : status, completion pulse, final value, progress, sticky error
//   wrap : master side of the wrapper link
module redun_sq_driver #(
    parameter int NUM_WRDS    = redun_mont_pkg::NUM_WRDS,
    parameter int WRD_BITS    = redun_mont_pkg::WRD_BITS,
    parameter int CNT_BITS    = 64,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  redun_mont_pkg::redun0_t i_sq,
    input  logic [CNT_BITS-1:0]     i_iter,
    output logic                    o_busy,
    output logic                    o_done,
    output redun_mont_pkg::redun0_t o_sq,
    output logic [CNT_BITS-1:0]     o_iter_cnt,
    output logic [1:0]              o_err,
    redun_sq_driver_if.master       wrap
);
    import redun_mont_pkg::*;

    localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;

    drv_state_t state_q, state_d;
    drv_err_t err_q, err_d;
    logic [NUM_WRDS-1:0][WRD_BITS-1:0] cur_q, cur_d;
    logic [CNT_BITS-1:0] tgt_q, tgt_d, cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic done_q, done_d, wst_q, wst_d;
    redun0_t sq_q, sq_d, wsq_q, wsq_d;
    logic accept, take, spur, lock_lost, timeout;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            err_q   <= ERR_NONE;
            cur_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            wst_q   <= 1'b0;
            sq_q    <= '0;
            wsq_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            wst_q   <= wst_d;
            sq_q    <= sq_d;
            wsq_q   <= wsq_d;
        end
    end

    // Lock loss beats a same-cycle result; a result beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ERR: if (i_start) state_d = i_iter == '0 ? S_DONE : S_WAIT_LOCK;
            S_WAIT_LOCK:   if (wrap.locked) state_d = S_ISSUE;
            S_ISSUE:       state_d = wrap.locked ? S_WAIT_RES : S_ERR;
            S_WAIT_RES:    state_d = !wrap.locked ? S_ERR :
                                     wrap.valid ? (cnt_q + 1'b1 == tgt_q ? S_DONE : S_ISSUE) :
                                     tmo_q == TW'(TIMEOUT_CYC - 1) ? S_ERR : S_WAIT_RES;
            S_DONE:        state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept    = (state_q == S_IDLE || state_q == S_ERR) && i_start;
        take      = state_q == S_WAIT_RES && wrap.locked && wrap.valid;
        spur      = wrap.valid && (state_q inside {S_IDLE, S_WAIT_LOCK, S_ISSUE, S_DONE});
        lock_lost = (state_q == S_ISSUE || state_q == S_WAIT_RES) && !wrap.locked;
        timeout   = state_q == S_WAIT_RES && wrap.locked && !wrap.valid && tmo_q == TW'(TIMEOUT_CYC - 1);
        err_d     = lock_lost ? ERR_LOCK : timeout ? ERR_TIMEOUT : spur ? ERR_SPUR : accept ? ERR_NONE : err_q;
        cur_d     = accept ? i_sq : take ? wrap.sq_out : cur_q;
        tgt_d     = accept ? i_iter : tgt_q;
        cnt_d     = accept ? '0 : take ? cnt_q + 1'b1 : cnt_q;
        tmo_d     = state_q == S_ISSUE ? '0 : state_q == S_WAIT_RES ? tmo_q + 1'b1 : tmo_q;
        // The request strobe is withheld if lock drops during ISSUE, so nothing is sent on an unlocked link.
        wst_d     = state_q == S_ISSUE && wrap.locked;
        wsq_d     = wst_d ? cur_q : wsq_q;
        done_d    = state_q == S_DONE;
        sq_d      = done_d ? cur_q : sq_q;
    end

    always_comb begin
        o_busy      = state_q inside {S_WAIT_LOCK, S_ISSUE, S_WAIT_RES};
        o_done      = done_q;
        o_sq        = sq_q;
        o_iter_cnt  = cnt_q;
        o_err       = err_q;
        wrap.start  = wst_q;
        wrap.sq_in  = wsq_q;
    end
endmodule
